// File: rtl/bits_to_bytes_stream.sv
// Packs a frame of FRAME_BITS bits (IN_W per beat, little-endian) into bytes on a valid/ready stream.
// Byte appears one cycle after its completing beat; a completing beat stalls only while the output register is full and not draining.
module bits_to_bytes_stream #(
    parameter int FRAME_BITS = 2048,
    parameter int IN_W       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_bits,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_byte,
    output logic            out_last
);

    localparam int BEATS  = 8 / IN_W;
    localparam int POS_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NBYTES = FRAME_BITS / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t             state_q;
    logic [7:0]         acc_q;
    logic [7:0]         byte_d;
    logic [POS_W-1:0]   pos_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         out_byte_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic               done_q;
    logic               completing;
    logic               beat_acc;
    logic               out_hs;

    assign completing = (pos_q == POS_LAST);
    assign in_ready   = (state_q == RUN) && (!completing || !out_valid_q || out_ready);
    assign beat_acc   = in_valid && in_ready;
    assign out_hs     = out_valid_q && out_ready;

    // Accumulator with the current beat merged into its slot.
    always_comb begin
        byte_d = acc_q;
        for (int k = 0; k < 8; k++) begin
            if ((k / IN_W) == int'(pos_q)) begin
                byte_d[k] = in_bits[k % IN_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            pos_q       <= '0;
            cnt_q       <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            pos_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (out_hs) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        acc_q   <= '0;
                        pos_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    if (beat_acc) begin
                        if (completing) begin
                            // A reload here overrides the handshake clear above.
                            out_byte_q  <= byte_d;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (cnt_q == CNT_LAST);
                            acc_q       <= '0;
                            pos_q       <= '0;
                            cnt_q       <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_LAST) begin
                                state_q <= FLUSH;
                            end
                        end else begin
                            acc_q <= byte_d;
                            pos_q <= pos_q + POS_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (out_hs) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/bits_to_bytes_stream.md
# bits_to_bytes_stream

Streaming, frame-sequenced bit-to-byte packer for Kyber encode paths. The block accepts a frame of FRAME_BITS bits, IN_W bits per beat, and packs them little-endian: frame bit i lands in byte i/8 at bit position i%8. It emits FRAME_BITS/8 bytes over a valid/ready stream. Bytes go to the byte-oriented hash/output stage, and the block sequences the frame with start/done.

## Interface
- FRAME_BITS, 2048: bits per frame; multiple of 8 and of IN_W.
- IN_W, 4: bits per input beat; one of 1, 2, 4, 8.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame start; ignored unless state is IDLE.
- abort  in  1  synchronous abort; returns the block to IDLE from any state.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle pulse after the last byte handshakes.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_bits  in  IN_W  input beat; in_bits[k] is frame bit beat*IN_W+k.
- out_valid  out  1  output byte valid.
- out_ready  in  1  downstream accepts the byte when out_valid && out_ready.
- out_byte  out  8  packed byte.
- out_last  out  1  high with the final byte of the frame.

## Operation
- FSM states:
  - IDLE: start → RUN; clears the accumulator and counters.
  - RUN: the final byte is loaded into the output register → FLUSH.
  - FLUSH: handshake of the final byte → IDLE, with done=1 for that single cycle.
  - abort in any state → IDLE next cycle; clears out_valid, out_last, the accumulator and counters; no done pulse. abort has priority over start and over handshakes in the same cycle.
- Accumulator: acc[7:0] and beat position pos, 0..8/IN_W-1.
  - On an accepted beat, bits acc[pos*IN_W +: IN_W] are set to in_bits.
  - pos increments by 1 and wraps to 0 after 8/IN_W beats.
- Completing beat (pos == 8/IN_W-1):
  - The full byte, with the current beat merged in, is written to the output register; out_valid=1.
  - acc is cleared and byte_cnt increments.
  - out_last=1 when byte_cnt == FRAME_BITS/8-1 before the increment.
- in_ready = (state==RUN) && (pos != 8/IN_W-1 || !out_valid || out_ready).
  - in_ready depends combinationally on out_ready.
  - A non-completing beat is never blocked by a full output register.
- Output register: holds its value while out_valid && !out_ready. It is cleared (out_valid=0) on a handshake unless it is reloaded in the same cycle.
- Simultaneous handshake and reload: the new byte replaces the old one, out_valid stays 1, and the block sustains one byte per 8/IN_W cycles.
- In FLUSH, in_ready=0; extra input beats are not consumed.
- start while busy: no effect.
- byte_cnt width: $clog2(FRAME_BITS/8+1).

## Timing
- Reset values: out_valid=0, out_byte=0, out_last=0, in_ready=0, busy=0, done=0; state=IDLE; acc, pos and byte_cnt are 0.
- start at cycle t: busy=1 and in_ready can assert at t+1.
- Latency: the byte is visible on out_byte/out_valid in the cycle after its completing beat is accepted.
- done: asserts in the cycle after the final out handshake, alongside busy=0. The next start is accepted in that same cycle (state is IDLE).
- Full throughput with out_ready held high: FRAME_BITS/IN_W input cycles. done follows 2 cycles after the last input beat (one cycle out_valid, one cycle done).
- Input bits of a beat with in_valid=0 are don't-care and do not affect acc.

## Test plan
- IN_W=4, FRAME_BITS=16, beats 0x3, 0xA, 0xF, 0x0, out_ready=1 → out_byte 0xA3, then 0x0F with out_last=1; done 2 cycles after the 4th beat; busy falls with done.
- IN_W=1, FRAME_BITS=8, bits 1,0,0,0,0,0,0,1 → single byte 0x81 with out_last=1.
- Backpressure: IN_W=8, FRAME_BITS=24, out_ready=0 for 5 cycles after the first byte:
  - out_byte holds the first byte;
  - in_ready drops on the second completing beat;
  - no byte is lost or duplicated;
  - output sequence equals the input.
- Abort mid-frame after 3 of 8 bytes → next cycle out_valid=0, busy=0, no done; a new start with fresh data produces the correct 8 bytes from byte 0.
- start pulsed in RUN and FLUSH → ignored; byte count stays FRAME_BITS/8. Reset asserted mid-frame → all outputs 0 immediately, asynchronously.
- Random IN_W ∈ {1,2,4,8}, FRAME_BITS=2048, random valid/ready throttling → scoreboard checks byte[j] bit b equals frame bit 8j+b, out_last only on byte 255, and exactly one done per frame.
